lsu_dispatch: RTL

- Sits directly downstream of lsu_bypass.
- Consumes the head entry of its request buffer (lsu_ctrl) and routes it to the load unit or the store unit through one registered valid/ready stage per path.
- Generates the pop_ld/pop_st pulses that retire the head entry.
- Screens misaligned accesses and stalls a load that would overtake a pending store to the same doubleword.

---
 rtl/lsu_dispatch_pkg.sv | 44 ++++
 rtl/lsu_dispatch_slot.sv | 41 ++++
 rtl/lsu_dispatch.sv | 99 +++++++++
 3 files changed

// File: rtl/lsu_dispatch_pkg.sv
// rtl/lsu_dispatch_pkg.sv - shared types and constants for the LSU dispatch stage
//
// Purpose: request record carried from the bypass buffer to the load/store
// units, access size encodings, misaligned exception causes and the
// alignment helper used by the dispatch logic.
package lsu_dispatch_pkg;

  localparam int VLEN          = 64;
  localparam int XLEN          = 64;
  localparam int TRANS_ID_BITS = 3;

  // Access size encodings (log2 of the byte count)
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Exception causes reported for a misaligned access
  localparam logic [XLEN-1:0] CAUSE_LD_MISALIGNED = XLEN'(4);
  localparam logic [XLEN-1:0] CAUSE_ST_MISALIGNED = XLEN'(6);

  typedef struct packed {
    logic [VLEN-1:0]          vaddr;
    logic [XLEN-1:0]          data;
    logic [XLEN/8-1:0]        be;
    logic [1:0]               size;
    logic                     is_load;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } lsu_ctrl_t;

  // An access is misaligned when any address bit below its natural size is set
  function automatic logic addr_misaligned(input logic [1:0] size, input logic [2:0] lsb);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_H:    mis = lsb[0];
      SZ_W:    mis = |lsb[1:0];
      SZ_D:    mis = |lsb[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_dispatch_slot.sv
// rtl/lsu_dispatch_slot.sv - one-entry valid/ready pipeline register with flush
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            drops the held entry (valid cleared next cycle)
//   wr_en, wr_data   load a new entry (caller guarantees free is high)
//   req, valid       registered request and its valid
//   ready            downstream accepts the held entry
//   free             slot can take a new entry this cycle (empty or draining)
module lsu_dispatch_slot
  import lsu_dispatch_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      wr_en,
  input  lsu_ctrl_t wr_data,
  output lsu_ctrl_t req,
  output logic      valid,
  input  logic      ready,
  output logic      free
);

  // Draining and refilling in the same cycle keeps full throughput
  assign free = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      req   <= wr_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lsu_dispatch.sv
// rtl/lsu_dispatch.sv - routes the LSU head request to the load or store unit
//
// Ports:
//   clk_i, rst_ni, flush_i               clock, async active-low reset, flush
//   lsu_ctrl_i, lsu_ctrl_valid_i         head entry of the bypass buffer
//   pop_ld_o, pop_st_o                   head retired this cycle (combinational)
//   ld_req_o, ld_valid_o, ld_ready_i     registered load request channel
//   st_req_o, st_valid_o, st_ready_i     registered store request channel
//   ex_valid_o, ex_trans_id_o,
//   ex_is_store_o                        misaligned exception pulse
module lsu_dispatch
  import lsu_dispatch_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  lsu_ctrl_t                lsu_ctrl_i,
  input  logic                     lsu_ctrl_valid_i,
  output logic                     pop_ld_o,
  output logic                     pop_st_o,
  output lsu_ctrl_t                ld_req_o,
  output logic                     ld_valid_o,
  input  logic                     ld_ready_i,
  output lsu_ctrl_t                st_req_o,
  output logic                     st_valid_o,
  input  logic                     st_ready_i,
  output logic                     ex_valid_o,
  output logic [TRANS_ID_BITS-1:0] ex_trans_id_o,
  output logic                     ex_is_store_o
);

  logic misaligned;
  logic hazard;
  logic ld_free;
  logic st_free;
  logic head_go;
  logic accept_ld;
  logic accept_st;

  assign misaligned = addr_misaligned(lsu_ctrl_i.size, lsu_ctrl_i.vaddr[2:0]);

  // A load must not overtake a stalled store to the same doubleword
  assign hazard = st_valid_o && !st_ready_i &&
                  (st_req_o.vaddr[VLEN-1:3] == lsu_ctrl_i.vaddr[VLEN-1:3]);

  // rst_ni in the qualifier keeps pops quiet while reset is held
  assign head_go = lsu_ctrl_valid_i && !flush_i && rst_ni;

  // Misaligned heads retire straight into the exception path, so they never
  // wait on a busy slot or a hazard
  assign accept_ld = head_go && lsu_ctrl_i.is_load &&
                     (misaligned || (ld_free && !hazard));
  assign accept_st = head_go && !lsu_ctrl_i.is_load &&
                     (misaligned || st_free);

  assign pop_ld_o = accept_ld;
  assign pop_st_o = accept_st;

  lsu_dispatch_slot u_ld_slot (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .flush   (flush_i),
    .wr_en   (accept_ld && !misaligned),
    .wr_data (lsu_ctrl_i),
    .req     (ld_req_o),
    .valid   (ld_valid_o),
    .ready   (ld_ready_i),
    .free    (ld_free)
  );

  lsu_dispatch_slot u_st_slot (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .flush   (flush_i),
    .wr_en   (accept_st && !misaligned),
    .wr_data (lsu_ctrl_i),
    .req     (st_req_o),
    .valid   (st_valid_o),
    .ready   (st_ready_i),
    .free    (st_free)
  );

  // Exception pulse; accept is already blocked under flush, so a flush
  // naturally clears it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_o    <= 1'b0;
      ex_trans_id_o <= '0;
      ex_is_store_o <= 1'b0;
    end else begin
      ex_valid_o <= (accept_ld || accept_st) && misaligned;
      if ((accept_ld || accept_st) && misaligned) begin
        ex_trans_id_o <= lsu_ctrl_i.trans_id;
        ex_is_store_o <= !lsu_ctrl_i.is_load;
      end
    end
  end

endmodule
